// File: rtl/rtc_bcd_timekeeper.sv
// BCD HH:MM:SS timekeeper with MODE/INC pushbutton time setting.
// Feeds the LCD line sequencer with six digits, a field-blink flag and an update strobe.

module rtc_key_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,   // raw pin, active-low, asynchronous
  output logic press_o    // one-cycle pulse on debounced 1->0
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;

  // Synchronizer resets to "released" so leaving reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      sync_q  <= {sync_q[0], key_n_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    cnt_d   = '0;
    level_d = level_q;
    press_o = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
        press_o = level_q;   // only the released->pressed transition is an event
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

endmodule

module rtc_bcd_timekeeper #(
  parameter int CLK_HZ     = 50000000,
  parameter int DEB_CYCLES = 1000000,
  parameter int INIT_HOUR  = 12,
  parameter int INIT_MIN   = 30,
  parameter int INIT_SEC   = 40
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iKEY_MODE,
  input  logic       iKEY_INC,
  output logic [3:0] oHOUR_1,
  output logic [3:0] oHOUR_0,
  output logic [3:0] oMIN_1,
  output logic [3:0] oMIN_0,
  output logic [3:0] oSEC_1,
  output logic [3:0] oSEC_0,
  output logic [1:0] oMODE,
  output logic       oBLINK,
  output logic       oUPDATE
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SET_SEC = 2'd3
  } mode_e;

  typedef struct packed {
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
  } bcd_time_t;

  localparam int PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PRE_HALF = PW'(CLK_HZ / 2);

  localparam bcd_time_t INIT_TIME = {
    4'(INIT_HOUR / 10), 4'(INIT_HOUR % 10),
    4'(INIT_MIN  / 10), 4'(INIT_MIN  % 10),
    4'(INIT_SEC  / 10), 4'(INIT_SEC  % 10)
  };

  // Two-digit BCD increment modulo 60 / modulo 24; inputs are always valid BCD.
  function automatic logic [7:0] inc_mod60(input logic [7:0] v);
    if (v[3:0] != 4'd9) return {v[7:4], v[3:0] + 4'd1};
    if (v[7:4] == 4'd5) return 8'h00;
    return {v[7:4] + 4'd1, 4'd0};
  endfunction

  function automatic logic [7:0] inc_mod24(input logic [7:0] v);
    if (v == 8'h23)     return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  logic mode_ev, inc_ev, tick;

  rtc_key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .clk     (iCLK),
    .rst_n   (iRST_N),
    .key_n_i (iKEY_MODE),
    .press_o (mode_ev)
  );

  rtc_key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
    .clk     (iCLK),
    .rst_n   (iRST_N),
    .key_n_i (iKEY_INC),
    .press_o (inc_ev)
  );

  mode_e         mode_q, mode_d;
  bcd_time_t     time_q, time_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          update_q, update_d;

  assign tick = (presc_q == PRE_LAST);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      mode_q   <= RUN;
      time_q   <= INIT_TIME;
      presc_q  <= '0;
      update_q <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      time_q   <= time_d;
      presc_q  <= presc_d;
      update_q <= update_d;
    end
  end

  always_comb begin
    mode_d  = mode_q;
    time_d  = time_q;
    presc_d = tick ? '0 : presc_q + 1'b1;

    // MODE beats a same-cycle INC; a tick in RUN is still applied before leaving.
    unique case (mode_q)
      RUN: begin
        if (tick) begin
          time_d.sec = inc_mod60(time_q.sec);
          if (time_q.sec == 8'h59) begin
            time_d.min = inc_mod60(time_q.min);
            if (time_q.min == 8'h59) time_d.hour = inc_mod24(time_q.hour);
          end
        end
      end
      SET_HR:  if (inc_ev && !mode_ev) time_d.hour = inc_mod24(time_q.hour);
      SET_MIN: if (inc_ev && !mode_ev) time_d.min  = inc_mod60(time_q.min);
      SET_SEC: if (inc_ev && !mode_ev) time_d.sec  = inc_mod60(time_q.sec);
      default: ;
    endcase

    if (mode_ev) begin
      unique case (mode_q)
        RUN:     mode_d = SET_HR;
        SET_HR:  mode_d = SET_MIN;
        SET_MIN: mode_d = SET_SEC;
        SET_SEC: mode_d = RUN;
        default: mode_d = RUN;
      endcase
      // Restart the second so the first tick after setting lands a full second later.
      if (mode_q == SET_SEC) presc_d = '0;
    end

    update_d = (time_d != time_q) || (mode_d != mode_q);
  end

  assign oHOUR_1 = time_q.hour[7:4];
  assign oHOUR_0 = time_q.hour[3:0];
  assign oMIN_1  = time_q.min[7:4];
  assign oMIN_0  = time_q.min[3:0];
  assign oSEC_1  = time_q.sec[7:4];
  assign oSEC_0  = time_q.sec[3:0];
  assign oMODE   = mode_q;
  assign oBLINK  = (mode_q == RUN) || (presc_q < PRE_HALF);
  assign oUPDATE = update_q;

endmodule

// File: tb/tb_rtc_bcd_timekeeper.sv
// Scoreboard bench for rtc_bcd_timekeeper: expected {mode,digits} queued at stimulus, popped on oUPDATE.

module tb_rtc_bcd_timekeeper;

  localparam int CLK_HZ = 10;
  localparam int DEB    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_mode = 1'b1;
  logic key_inc = 1'b1;

  always #5 clk = ~clk;

  logic [3:0] h1, h0, m1, m0, s1, s0;
  logic [1:0] mode;
  logic       blink, upd;

  rtc_bcd_timekeeper #(.CLK_HZ(CLK_HZ), .DEB_CYCLES(DEB),
                       .INIT_HOUR(12), .INIT_MIN(30), .INIT_SEC(40)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iKEY_MODE(key_mode), .iKEY_INC(key_inc),
    .oHOUR_1(h1), .oHOUR_0(h0), .oMIN_1(m1), .oMIN_0(m0), .oSEC_1(s1), .oSEC_0(s0),
    .oMODE(mode), .oBLINK(blink), .oUPDATE(upd)
  );

  // Carry-chain instances, keys idle.
  logic [3:0] a_h1, a_h0, a_m1, a_m0, a_s1, a_s0, b_h1, b_h0, b_m1, b_m0, b_s1, b_s0;
  logic [3:0] c_h1, c_h0, c_m1, c_m0, c_s1, c_s0;
  logic [1:0] a_mode, b_mode, c_mode;
  logic       a_blink, b_blink, c_blink, a_upd, b_upd, c_upd;

  rtc_bcd_timekeeper #(.CLK_HZ(CLK_HZ), .DEB_CYCLES(DEB),
                       .INIT_HOUR(23), .INIT_MIN(59), .INIT_SEC(59)) dut_a (
    .iCLK(clk), .iRST_N(rst_n), .iKEY_MODE(1'b1), .iKEY_INC(1'b1),
    .oHOUR_1(a_h1), .oHOUR_0(a_h0), .oMIN_1(a_m1), .oMIN_0(a_m0), .oSEC_1(a_s1), .oSEC_0(a_s0),
    .oMODE(a_mode), .oBLINK(a_blink), .oUPDATE(a_upd)
  );

  rtc_bcd_timekeeper #(.CLK_HZ(CLK_HZ), .DEB_CYCLES(DEB),
                       .INIT_HOUR(9), .INIT_MIN(59), .INIT_SEC(59)) dut_b (
    .iCLK(clk), .iRST_N(rst_n), .iKEY_MODE(1'b1), .iKEY_INC(1'b1),
    .oHOUR_1(b_h1), .oHOUR_0(b_h0), .oMIN_1(b_m1), .oMIN_0(b_m0), .oSEC_1(b_s1), .oSEC_0(b_s0),
    .oMODE(b_mode), .oBLINK(b_blink), .oUPDATE(b_upd)
  );

  rtc_bcd_timekeeper #(.CLK_HZ(CLK_HZ), .DEB_CYCLES(DEB),
                       .INIT_HOUR(19), .INIT_MIN(59), .INIT_SEC(59)) dut_c (
    .iCLK(clk), .iRST_N(rst_n), .iKEY_MODE(1'b1), .iKEY_INC(1'b1),
    .oHOUR_1(c_h1), .oHOUR_0(c_h0), .oMIN_1(c_m1), .oMIN_0(c_m0), .oSEC_1(c_s1), .oSEC_0(c_s0),
    .oMODE(c_mode), .oBLINK(c_blink), .oUPDATE(c_upd)
  );

  wire [23:0] digits   = {h1, h0, m1, m0, s1, s0};
  wire [25:0] cur_st   = {mode, digits};
  wire [23:0] a_digits = {a_h1, a_h0, a_m1, a_m0, a_s1, a_s0};
  wire [23:0] b_digits = {b_h1, b_h0, b_m1, b_m0, b_s1, b_s0};
  wire [23:0] c_digits = {c_h1, c_h0, c_m1, c_m0, c_s1, c_s0};

  int n_vec = 0;
  int n_err = 0;
  int upd_cnt = 0;
  int a_upd_cnt = 0;
  logic [25:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [25:0] st(input int md, input int h, input int m, input int s);
    return {2'(md), 4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  // Every update strobe must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n && upd) begin
      upd_cnt++;
      if (exp_q.size() > 0) check("upd_state", 32'(cur_st), 32'(exp_q.pop_front()));
      else check("upd_queued", 32'(exp_q.size()), 32'd1);
    end
    if (rst_n && a_upd) a_upd_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_mode();
    key_mode = 1'b0; step(8);
    key_mode = 1'b1; step(8);
  endtask

  task automatic press_inc();
    key_inc = 1'b0; step(8);
    key_inc = 1'b1; step(8);
  endtask

  initial begin
    int u0, tog, waited, n;
    logic prev;

    // 1. Reset and first tick.
    step(3);
    rst_n = 1'b1;                       // p = 0
    check("rst_digits", 32'(digits), 32'h123040);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_blink", 32'(blink), 32'd1);
    check("rst_upd", 32'(upd), 32'd0);
    check("rst_carry_a", 32'(a_digits), 32'h235959);
    exp_q.push_back(st(0, 12, 30, 41));
    step(10);                           // p = 10
    check("tick_sec", 32'({s1, s0}), 32'h41);
    check("carry_23", 32'(a_digits), 32'h000000);
    check("carry_09", 32'(b_digits), 32'h100000);
    check("carry_19", 32'(c_digits), 32'h200000);
    step(9);                            // p = 19
    check("one_upd", 32'(upd_cnt), 32'd1);
    check("one_upd_carry", 32'(a_upd_cnt), 32'd1);

    // 3. Enter SET_HR; tick at p=20 lands first.
    exp_q.push_back(st(0, 12, 30, 42));
    exp_q.push_back(st(1, 12, 30, 42));
    step(1);                            // p = 20
    key_mode = 1'b0;
    step(10);                           // p = 30
    key_mode = 1'b1;
    check("set_hr_mode", 32'(mode), 32'd1);
    check("blink_on", 32'(blink), 32'd1);
    u0 = upd_cnt;
    step(5);                            // p = 35
    check("blink_off", 32'(blink), 32'd0);
    tog = 0;
    prev = blink;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (blink != prev) tog++;
      prev = blink;
    end
    check("blink_toggles", 32'(tog), 32'd10);
    check("frozen_time", 32'(digits), 32'h123042);
    check("frozen_no_upd", 32'(upd_cnt - u0), 32'd0);

    for (int h = 13; h <= 23; h++) begin
      exp_q.push_back(st(1, h, 30, 42));
      press_inc();
    end
    check("hour_23", 32'({h1, h0}), 32'h23);
    exp_q.push_back(st(1, 0, 30, 42));
    press_inc();
    check("hour_wrap", 32'(digits), 32'h003042);

    // 4. SET_MIN wrap, then SET_SEC -> RUN -> SET_HR.
    exp_q.push_back(st(2, 0, 30, 42));
    press_mode();
    for (int m = 31; m <= 59; m++) begin
      exp_q.push_back(st(2, 0, m, 42));
      press_inc();
    end
    check("min_59", 32'({m1, m0}), 32'h59);
    exp_q.push_back(st(2, 0, 0, 42));
    press_inc();
    check("min_wrap", 32'(digits), 32'h000042);
    exp_q.push_back(st(3, 0, 0, 42));
    press_mode();
    check("mode_seq_3", 32'(mode), 32'd3);

    exp_q.push_back(st(0, 0, 0, 42));
    exp_q.push_back(st(0, 0, 0, 43));
    key_mode = 1'b0;
    waited = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      waited = i;
      if (mode == 2'd0) break;
    end
    key_mode = 1'b1;
    check("mode_seq_0", 32'(mode), 32'd0);
    check("press_latency_ok", 32'(waited >= 5 && waited <= 7), 32'd1);
    n = 0;
    for (int i = 1; i <= 15; i++) begin
      step(1);
      n = i;
      if ({s1, s0} == 8'h43) break;
    end
    check("first_tick_cycles", 32'(n), 32'd10);
    exp_q.push_back(st(1, 0, 0, 43));
    press_mode();
    check("mode_seq_1", 32'(mode), 32'd1);

    // 5. Glitches, then simultaneous MODE+INC.
    u0 = upd_cnt;
    repeat (5) begin
      key_inc = 1'b0; step(3);
      key_inc = 1'b1; step(3);
    end
    step(8);
    check("glitch_no_upd", 32'(upd_cnt - u0), 32'd0);
    check("glitch_time", 32'(digits), 32'h000043);
    u0 = upd_cnt;
    exp_q.push_back(st(2, 0, 0, 43));
    key_mode = 1'b0; key_inc = 1'b0; step(8);
    key_mode = 1'b1; key_inc = 1'b1; step(8);
    check("simul_mode", 32'(mode), 32'd2);
    check("simul_hour", 32'({h1, h0}), 32'h00);
    check("simul_one_upd", 32'(upd_cnt - u0), 32'd1);

    // 6. Async reset mid-debounce in SET_MIN.
    check("sb_empty_pre_rst", 32'(exp_q.size()), 32'd0);
    key_inc = 1'b0;
    step(4);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_digits", 32'(digits), 32'h123040);
    check("async_rst_mode", 32'(mode), 32'd0);
    check("async_rst_blink", 32'(blink), 32'd1);
    check("async_rst_upd", 32'(upd), 32'd0);
    key_inc = 1'b1;
    step(1);
    rst_n = 1'b1;
    u0 = upd_cnt;
    step(9);
    check("post_rst_no_upd", 32'(upd_cnt - u0), 32'd0);
    check("post_rst_state", 32'(cur_st), 32'(st(0, 12, 30, 40)));
    exp_q.push_back(st(0, 12, 30, 41));
    step(3);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
